seg_fade_driver: RTL and testbench

Output stage between the seven-segment pattern generator and the `uo_out[6:0]` pads. It takes the 7-bit segment pattern and a 4-bit brightness level and drives the pads with PWM dimming. Whenever the incoming pattern changes, the old pattern fades out to dark, the new pattern is swapped in, and it fades back up to the set brightness. This turns hard digit and animation steps into soft crossfades.

---
 rtl/seg_fade_driver.sv | 114 +++++++++++
 tb/tb_seg_fade_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_fade_driver.sv
// seg_fade_driver: PWM-dimmed seven-segment output stage.
// Define SEG_FADE_EN to turn pattern changes into fade-out / swap / fade-in crossfades.
module seg_fade_driver #(
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned STEP_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [6:0]          seg_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [6:0]          seg_out,
  output logic                busy
);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [6:0]          shown_q, shown_d;
  logic [6:0]          seg_out_q;
  logic [PWM_BITS-1:0] level;
  logic                on;

  // full-scale level is 100 % duty rather than (2^N-1)/2^N
  assign on = (level == '1) || (level > pwm_cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      shown_q   <= '0;
      seg_out_q <= '0;
    end else if (ena) begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      shown_q   <= shown_d;
      seg_out_q <= shown_q & {7{on}};
    end
  end

`ifdef SEG_FADE_EN
  typedef enum logic [1:0] {STEADY, FADE_OUT, FADE_IN} state_e;

  state_e              state_q, state_d;
  logic [7:0]          pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                busy_q;
  logic                period_end, tick;

  always_comb begin
    period_end = (pwm_cnt_q == '1);
    tick       = period_end && (pre_cnt_q == 8'(STEP_DIV - 1));
    pre_cnt_d  = pre_cnt_q;
    if (tick)
      pre_cnt_d = '0;
    else if (period_end)
      pre_cnt_d = pre_cnt_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    shown_d = shown_q;
    case (state_q)
      STEADY: begin
        level_d = brightness;
        if (seg_in != shown_q)
          state_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (tick) begin
          if (level_q == '0) begin
            shown_d = seg_in;
            state_d = FADE_IN;
          end else begin
            level_d = level_q - PWM_BITS'(1);
          end
        end
      end
      FADE_IN: begin
        // a new pattern takes priority; the clamp is checked every cycle, the ramp only on ticks
        if (seg_in != shown_q)
          state_d = FADE_OUT;
        else if (level_q >= brightness) begin
          level_d = brightness;
          state_d = STEADY;
        end else if (tick)
          level_d = level_q + PWM_BITS'(1);
      end
      default: state_d = FADE_IN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FADE_IN;
      level_q   <= '0;
      pre_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else if (ena) begin
      state_q   <= state_d;
      level_q   <= level_d;
      pre_cnt_q <= pre_cnt_d;
      busy_q    <= (state_d != STEADY);
    end
  end

  assign level = level_q;
  assign busy  = busy_q;
`else
  assign level   = brightness;
  assign shown_d = seg_in;
  assign busy    = 1'b0;
`endif

  assign seg_out = seg_out_q;

endmodule

// File: tb/tb_seg_fade_driver.sv
`timescale 1ns/1ps
module tb_seg_fade_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [6:0] seg_in = '0;
  logic [3:0] brightness = '0;
  logic [6:0] seg_out;
  logic       busy;

`ifdef SEG_FADE_EN
  localparam int EXP_BUSY_RST = 1;
`else
  localparam int EXP_BUSY_RST = 0;
`endif

  seg_fade_driver #(.PWM_BITS(4), .STEP_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in),
    .brightness(brightness), .seg_out(seg_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] bright;
    int         exp_on;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] seg;
    int         exp_on;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic wait_idle(input int unsigned bound, output int unsigned cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // one PWM period: how many samples show the pattern, and how many show anything else but dark
  task automatic measure(input logic [6:0] seg, output int on_cnt, output int bad);
    on_cnt = 0;
    bad = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      @(negedge clk);
      if (seg_out == seg) on_cnt++;
      else if (seg_out != 7'h00) bad++;
    end
  endtask

  task automatic wait_pattern(input logic [6:0] seg, input int unsigned bound, output int unsigned cyc);
    cyc = 0;
    while (seg_out !== seg && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  vec_t vecs[7];

  initial begin
    int unsigned cyc;
    int on_cnt, bad, run, diffs;
    logic [6:0] frozen;
    exp_t e;

    vecs[0] = '{7'h06, 4'd4,  4};
    vecs[1] = '{7'h06, 4'd15, 16};
    vecs[2] = '{7'h06, 4'd0,  0};
    vecs[3] = '{7'h5B, 4'd1,  1};
    vecs[4] = '{7'h5B, 4'd14, 14};
    vecs[5] = '{7'h7F, 4'd8,  8};
    vecs[6] = '{7'h49, 4'd15, 16};

    // reset and first fade-in
    ena = 1'b1;
    brightness = 4'd15;
    seg_in = 7'h3F;
    repeat (3) @(negedge clk);
    check("rst_seg_out", seg_out, 0);
    check("rst_busy", busy, EXP_BUSY_RST);
    rst_n = 1'b1;
`ifdef SEG_FADE_EN
    @(negedge clk);
    check("fadein_busy", busy, 1);
    wait_idle(3000, cyc);
    check("fadein_idle", busy, 0);
    check("fadein_time_ok", int'(cyc >= 15*64 && cyc <= 17*64 + 8), 1);
`else
    @(negedge clk);
    check("lat_cycle1", seg_out, 0);
    @(negedge clk);
    check("lat_cycle2", seg_out, 7'h3F);
`endif
    measure(7'h3F, on_cnt, bad);
    check("fadein_on", on_cnt, 16);
    check("fadein_bad", bad, 0);

    // table: steady-state duty per brightness
    for (int unsigned i = 0; i < 7; i++) begin
      seg_in = vecs[i].seg;
      brightness = vecs[i].bright;
      sb.push_back('{$sformatf("duty%0d", i), vecs[i].seg, vecs[i].exp_on});
      wait_idle(4000, cyc);
      check($sformatf("duty%0d_idle", i), busy, 0);
      repeat (3) @(negedge clk);
      measure(sb[0].seg, on_cnt, bad);
      e = sb.pop_front();
      check({e.name, "_on"}, on_cnt, e.exp_on);
      check({e.name, "_bad"}, bad, 0);
    end

`ifdef SEG_FADE_EN
    // crossfade 06 -> 5B at full brightness
    seg_in = 7'h06;
    wait_idle(4000, cyc);
    check("xf_pre_idle", busy, 0);
    seg_in = 7'h5B;
    @(negedge clk);
    check("xf_busy_rise", busy, 1);
    begin
      int unsigned t, first_new;
      bit seen_new;
      int order_bad;
      t = 1; first_new = 0; seen_new = 0; order_bad = 0;
      while (busy !== 1'b0 && t < 2500) begin
        @(negedge clk);
        t++;
        if (seg_out == 7'h5B && !seen_new) begin seen_new = 1; first_new = t; end
        if (seg_out == 7'h06 && seen_new) order_bad++;
        if (seg_out != 7'h06 && seg_out != 7'h5B && seg_out != 7'h00) order_bad++;
      end
      check("xf_idle", busy, 0);
      check("xf_time_ok", int'(t >= 1900 && t <= 2100), 1);
      check("xf_swap_time_ok", int'(first_new >= 960 && first_new <= 1100), 1);
      check("xf_order", order_bad, 0);
    end

    // brightness clamp during fade-in
    seg_in = 7'h06;
    wait_pattern(7'h06, 2500, cyc);
    check("clamp_swapped", seg_out, 7'h06);
    repeat (640) @(negedge clk);
    check("clamp_pre_busy", busy, 1);
    brightness = 4'd3;
    repeat (3) @(negedge clk);
    check("clamp_busy", busy, 0);
    measure(7'h06, on_cnt, bad);
    check("clamp_on", on_cnt, 3);

    // pattern change while fading in: newest pattern wins at level 0
    brightness = 4'd15;
    repeat (3) @(negedge clk);
    seg_in = 7'h5B;
    wait_pattern(7'h5B, 2500, cyc);
    check("fi_swapped", seg_out, 7'h5B);
    repeat (400) @(negedge clk);
    check("fi_mid_busy", busy, 1);
    seg_in = 7'h4F;
    begin
      int stale;
      stale = 0;
      repeat (100) begin
        @(negedge clk);
        if (seg_out == 7'h4F) stale++;
      end
      seg_in = 7'h66;
      cyc = 0;
      while (busy !== 1'b0 && cyc < 3000) begin
        @(negedge clk);
        cyc++;
        if (seg_out == 7'h4F) stale++;
      end
      check("fi_idle", busy, 0);
      check("fi_no_stale", stale, 0);
    end
    measure(7'h66, on_cnt, bad);
    check("fi_on", on_cnt, 16);
    check("fi_bad", bad, 0);
`endif

    // ena freeze: stop on the first lit sample of a half-duty period
    brightness = 4'd8;
    seg_in = 7'h06;
    wait_idle(4000, cyc);
    check("frz_idle", busy, 0);
    repeat (20) @(negedge clk);
    cyc = 0;
    begin
      logic [6:0] prev;
      prev = seg_out;
      @(negedge clk);
      while (!(prev == 7'h00 && seg_out != 7'h00) && cyc < 40) begin
        prev = seg_out;
        @(negedge clk);
        cyc++;
      end
    end
    check("frz_edge_found", int'(cyc < 40), 1);
    ena = 1'b0;
    frozen = seg_out;
    diffs = 0;
    repeat (100) begin
      @(negedge clk);
      if (seg_out != frozen) diffs++;
    end
    check("frz_hold", diffs, 0);
    ena = 1'b1;
    run = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      @(negedge clk);
      if (seg_out == 7'h00) break;
      run++;
    end
    check("frz_resume_run", run, 7);

    // async reset between clock edges while frozen
    brightness = 4'd15;
    repeat (4) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    check("arst_pre", seg_out, 7'h06);
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg_out", seg_out, 0);
    check("arst_busy", busy, EXP_BUSY_RST);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
